// File: rtl/col_pkg.sv
`default_nettype none
// ============================================================================
// Module   : col_pkg
// Desc     : Shared widths, FSM states and preset table for the color-reduce
//            configuration scheduler.
// Revision : 1.0  initial release
// ============================================================================
package col_pkg;

    localparam int SEL_W     = 2;
    localparam int VAL_W     = 3;
    localparam int N_PRESETS = 4;
    localparam int N_CH      = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        APPLY      = 2'd2,
        GAP        = 2'd3
    } state_t;

    // Outer index is the preset id, inner index the channel (ch0 in the LSBs).
    localparam logic [N_PRESETS-1:0][N_CH-1:0][VAL_W-1:0] PRESET_TBL = {
        {3'd1, 3'd4, 3'd2},
        {3'd7, 3'd7, 3'd7},
        {3'd6, 3'd3, 3'd5},
        {3'd3, 3'd2, 3'd1}
    };

    function automatic logic [VAL_W-1:0] preset_val(input logic [1:0] pid,
                                                     input logic [1:0] ch);
        return PRESET_TBL[pid][ch];
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Desc     : Push-button synchronizer, stability filter and rising-edge pulse.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int                 c_cnt_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_pulse <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/col_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : col_cfg_sched
// Desc     : Arbitrates user/preset reduction settings and applies them to the
//            color-reduce config bus only during vertical blanking.
// Revision : 1.0  initial release
// ============================================================================
module col_cfg_sched
    import col_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_change,
    input  logic [SEL_W-1:0] sw_sels,
    input  logic [VAL_W-1:0] sw_vals,
    input  logic             preset_req,
    input  logic [1:0]       preset_id,
    input  logic             vblank,
    output logic [SEL_W-1:0] cfg_sels,
    output logic [VAL_W-1:0] cfg_vals,
    output logic             cfg_change,
    output logic             busy,
    output logic             applied
);

    localparam int                  c_hold_w   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_CYCLES - 1);

    logic w_usr_pulse;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_change),
        .o_pulse (w_usr_pulse)
    );

    state_t              r_state;
    logic                r_pend_u;
    logic [SEL_W-1:0]    r_pend_u_sel;
    logic [VAL_W-1:0]    r_pend_u_val;
    logic                r_pend_p;
    logic [1:0]          r_pend_pid;
    logic                r_is_preset;
    logic [1:0]          r_pid;
    logic [1:0]          r_ch;
    logic [SEL_W-1:0]    r_wsel;
    logic [VAL_W-1:0]    r_wval;
    logic [c_hold_w-1:0] r_hold;
    logic [SEL_W-1:0]    r_cfg_sels;
    logic [VAL_W-1:0]    r_cfg_vals;
    logic                r_cfg_change;
    logic                r_busy;
    logic                r_applied;
    logic [1:0]          w_ch_next;

    assign w_ch_next = r_ch + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pend_u     <= 1'b0;
            r_pend_u_sel <= '0;
            r_pend_u_val <= '0;
            r_pend_p     <= 1'b0;
            r_pend_pid   <= '0;
            r_is_preset  <= 1'b0;
            r_pid        <= '0;
            r_ch         <= '0;
            r_wsel       <= '0;
            r_wval       <= '0;
            r_hold       <= '0;
            r_cfg_sels   <= '0;
            r_cfg_vals   <= '0;
            r_cfg_change <= 1'b0;
            r_busy       <= 1'b0;
            r_applied    <= 1'b0;
        end else begin
            r_applied <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pend_p) begin
                        r_state     <= WAIT_BLANK;
                        r_busy      <= 1'b1;
                        r_is_preset <= 1'b1;
                        r_pid       <= r_pend_pid;
                        r_ch        <= 2'd0;
                        r_wsel      <= '0;
                        r_wval      <= preset_val(r_pend_pid, 2'd0);
                        r_pend_p    <= 1'b0;
                    end else if (r_pend_u) begin
                        r_state     <= WAIT_BLANK;
                        r_busy      <= 1'b1;
                        r_is_preset <= 1'b0;
                        r_wsel      <= r_pend_u_sel;
                        r_wval      <= r_pend_u_val;
                        r_pend_u    <= 1'b0;
                    end
                end
                WAIT_BLANK: begin
                    if (vblank) begin
                        r_state      <= APPLY;
                        r_hold       <= '0;
                        r_cfg_sels   <= r_wsel;
                        r_cfg_vals   <= r_wval;
                        r_cfg_change <= 1'b1;
                    end
                end
                APPLY: begin
                    // A write in progress always runs to completion, even if blank ends.
                    if (r_hold == c_hold_max) begin
                        r_state      <= GAP;
                        r_cfg_change <= 1'b0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                GAP: begin
                    if (r_is_preset && (r_ch < 2'd2)) begin
                        r_state <= WAIT_BLANK;
                        r_ch    <= w_ch_next;
                        r_wsel  <= w_ch_next;
                        r_wval  <= preset_val(r_pid, w_ch_next);
                    end else begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_applied <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // New requests take precedence over the clear done when one is accepted.
            if (w_usr_pulse) begin
                r_pend_u     <= 1'b1;
                r_pend_u_sel <= sw_sels;
                r_pend_u_val <= sw_vals;
            end
            if (preset_req) begin
                r_pend_p   <= 1'b1;
                r_pend_pid <= preset_id;
            end
        end
    end

    assign cfg_sels   = r_cfg_sels;
    assign cfg_vals   = r_cfg_vals;
    assign cfg_change = r_cfg_change;
    assign busy       = r_busy;
    assign applied    = r_applied;

endmodule
`default_nettype wire

// File: tb/tb_col_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_col_cfg_sched
// Desc     : Self-checking bench for col_cfg_sched against a write-queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_col_cfg_sched;

    localparam int DEB  = 16;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_change;
    logic [1:0] sw_sels;
    logic [2:0] sw_vals;
    logic       preset_req;
    logic [1:0] preset_id;
    logic       vblank;
    logic [1:0] cfg_sels;
    logic [2:0] cfg_vals;
    logic       cfg_change;
    logic       busy;
    logic       applied;

    col_cfg_sched #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_change (btn_change),
        .sw_sels    (sw_sels),
        .sw_vals    (sw_vals),
        .preset_req (preset_req),
        .preset_id  (preset_id),
        .vblank     (vblank),
        .cfg_sels   (cfg_sels),
        .cfg_vals   (cfg_vals),
        .cfg_change (cfg_change),
        .busy       (busy),
        .applied    (applied)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: debounced button events feed one-deep pending slots; an
    // accepted request becomes a queue of writes, each waiting for blank, held
    // HOLD cycles, then followed by one quiet cycle.
    int         tbl [4][3] = '{'{1, 2, 3}, '{5, 3, 6}, '{7, 7, 7}, '{2, 4, 1}};
    logic       m_s1, m_s2, m_level, m_upulse;
    int         m_run;
    logic       m_pend_u, m_pend_p;
    logic [1:0] m_pu_sel;
    logic [2:0] m_pu_val;
    int         m_pp_id;
    logic       m_busy;
    int         m_pos;
    logic [1:0] m_wq_sel [$];
    logic [2:0] m_wq_val [$];
    logic [1:0] m_sels;
    logic [2:0] m_vals;
    logic       m_change, m_applied;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_upulse = 0; m_run = 0;
        m_pend_u = 0; m_pend_p = 0; m_pu_sel = 0; m_pu_val = 0; m_pp_id = 0;
        m_busy = 0; m_pos = 0; m_wq_sel.delete(); m_wq_val.delete();
        m_sels = 0; m_vals = 0; m_change = 0; m_applied = 0;
    endtask

    task automatic model_step();
        logic new_pulse;
        new_pulse = 1'b0;
        if (m_s2 != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level   = m_s2;
                new_pulse = m_s2;
                m_run     = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn_change;

        m_applied = 1'b0;
        if (!m_busy) begin
            if (m_pend_p) begin
                for (int c = 0; c < 3; c++) begin
                    m_wq_sel.push_back(2'(c));
                    m_wq_val.push_back(3'(tbl[m_pp_id][c]));
                end
                m_pend_p = 0; m_busy = 1; m_pos = 0;
            end else if (m_pend_u) begin
                m_wq_sel.push_back(m_pu_sel);
                m_wq_val.push_back(m_pu_val);
                m_pend_u = 0; m_busy = 1; m_pos = 0;
            end
        end else if (m_pos == 0) begin
            if (vblank) begin
                m_pos = 1; m_sels = m_wq_sel[0]; m_vals = m_wq_val[0]; m_change = 1;
            end
        end else if (m_pos < HOLD) begin
            m_pos++;
        end else if (m_pos == HOLD) begin
            m_pos++; m_change = 0;
        end else begin
            void'(m_wq_sel.pop_front());
            void'(m_wq_val.pop_front());
            m_pos = 0;
            if (m_wq_sel.size() == 0) begin
                m_busy = 0; m_applied = 1;
            end
        end

        if (m_upulse) begin
            m_pend_u = 1; m_pu_sel = sw_sels; m_pu_val = sw_vals;
        end
        if (preset_req) begin
            m_pend_p = 1; m_pp_id = int'(preset_id);
        end
        m_upulse = new_pulse;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset)
                chk("reset_outputs", int'({cfg_sels, cfg_vals, cfg_change, busy, applied}), 0);
            else
                chk("outputs", int'({cfg_sels, cfg_vals, cfg_change, busy, applied}),
                    int'({m_sels, m_vals, m_change, m_busy, m_applied}));
        end
    end

    // Observed write log for the hand-computed directed expectations.
    int         n_change  = 0;
    int         n_applied = 0;
    logic [1:0] log_sel [$];
    logic [2:0] log_val [$];
    logic       prev_change = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (cfg_change && !prev_change) begin
                    log_sel.push_back(cfg_sels);
                    log_val.push_back(cfg_vals);
                end
                if (cfg_change) n_change++;
                if (applied)    n_applied++;
            end
            prev_change = reset ? cfg_change : 1'b0;
        end
    end

    task automatic clear_mon();
        n_change = 0; n_applied = 0; log_sel.delete(); log_val.delete();
    endtask

    function automatic int log_s(input int i);
        return (i < log_sel.size()) ? int'(log_sel[i]) : -1;
    endfunction

    function automatic int log_v(input int i);
        return (i < log_val.size()) ? int'(log_val[i]) : -1;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int n_high);
        btn_change = 1'b1;
        cyc(n_high);
        btn_change = 1'b0;
    endtask

    task automatic wait_change(input logic lvl, input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cfg_change !== lvl && k < budget);
        chk(name, int'(cfg_change), int'(lvl));
    endtask

    int exp_s [4] = '{0, 1, 2, 3};
    int exp_v [4] = '{5, 3, 6, 4};

    initial begin
        int k;
        int vb_left, btn_left;
        reset = 0; btn_change = 0; sw_sels = 0; sw_vals = 0;
        preset_req = 0; preset_id = 0; vblank = 0;

        // Reset held while all inputs toggle.
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            btn_change = 1'($urandom_range(0, 1));
            sw_sels    = 2'($urandom_range(0, 3));
            sw_vals    = 3'($urandom_range(0, 7));
            preset_req = 1'($urandom_range(0, 1));
            preset_id  = 2'($urandom_range(0, 3));
            vblank     = 1'($urandom_range(0, 1));
        end
        btn_change = 0; preset_req = 0; vblank = 1;
        cyc(1);
        reset = 1;
        cyc(3);
        chk("busy_after_reset", int'(busy), 0);

        // Single user write.
        clear_mon();
        sw_sels = 2'd2; sw_vals = 3'd5;
        press(20);
        cyc(40);
        chk("user_change_cycles", n_change, 4);
        chk("user_write_count", log_sel.size(), 1);
        chk("user_sel", log_s(0), 2);
        chk("user_val", log_v(0), 5);
        chk("user_applied", n_applied, 1);

        // Bounce rejection, then a clean press.
        clear_mon();
        repeat (6) begin
            btn_change = 1; cyc(5);
            btn_change = 0; cyc(5);
        end
        cyc(20);
        chk("bounce_no_change", n_change, 0);
        chk("bounce_idle", int'(busy), 0);
        sw_sels = 2'd1; sw_vals = 3'd3;
        press(20);
        cyc(40);
        chk("clean_change_cycles", n_change, 4);
        chk("clean_val", log_v(0), 3);
        chk("clean_applied", n_applied, 1);

        // Blank gating.
        clear_mon();
        vblank = 0; sw_sels = 2'd3; sw_vals = 3'd6;
        press(20);
        cyc(100);
        chk("gate_busy", int'(busy), 1);
        chk("gate_no_change", n_change, 0);
        vblank = 1;
        @(negedge clk);
        chk("gate_same_cycle", int'(cfg_change), 0);
        @(negedge clk);
        chk("gate_next_cycle", int'(cfg_change), 1);
        cyc(20);
        chk("gate_applied", n_applied, 1);
        chk("gate_val", log_v(0), 6);

        // Preset and user request landing in the same cycle.
        clear_mon();
        vblank = 1; sw_sels = 2'd3; sw_vals = 3'd4;
        btn_change = 1;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!m_upulse && k < 40);
        chk("usr_pulse_latency", k, 18);
        preset_req = 1; preset_id = 2'd1;
        cyc(1);
        preset_req = 0; btn_change = 0;
        cyc(80);
        chk("combo_write_count", log_sel.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("combo_sel%0d", i), log_s(i), exp_s[i]);
            chk($sformatf("combo_val%0d", i), log_v(i), exp_v[i]);
        end
        chk("combo_applied", n_applied, 2);
        chk("combo_change_cycles", n_change, 16);

        // Blank drop mid-preset, then async reset during channel 1.
        clear_mon();
        vblank = 1; preset_req = 1; preset_id = 2'd2;
        cyc(1);
        preset_req = 0;
        wait_change(1'b1, 20, "ch0_start");
        cyc(1);
        vblank = 0;
        cyc(30);
        chk("ch0_complete", n_change, 4);
        chk("ch1_waiting_busy", int'(busy), 1);
        chk("ch1_waiting_writes", log_sel.size(), 1);
        vblank = 1;
        wait_change(1'b1, 20, "ch1_start");
        chk("ch1_sel", int'(cfg_sels), 1);
        chk("ch1_val", int'(cfg_vals), 7);
        #2 reset = 0;
        #1;
        chk("async_rst_change", int'(cfg_change), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_sels", int'(cfg_sels), 0);
        chk("async_rst_vals", int'(cfg_vals), 0);
        cyc(3);
        reset = 1;
        cyc(20);
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_no_applied", n_applied, 0);

        // Randomized traffic against the model.
        vb_left = 0; btn_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (vb_left == 0) begin
                vblank  = ~vblank;
                vb_left = int'($urandom_range(5, 60));
            end
            vb_left--;
            if (btn_left == 0) begin
                btn_change = ~btn_change;
                if (btn_change)
                    btn_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 8))
                                                           : int'($urandom_range(18, 30));
                else
                    btn_left = int'($urandom_range(5, 40));
            end
            btn_left--;
            sw_sels    = 2'($urandom_range(0, 3));
            sw_vals    = 3'($urandom_range(0, 7));
            preset_req = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            preset_id  = 2'($urandom_range(0, 3));
            if (i == 1500) reset = 0;
            if (i == 1501) reset = 1;
            cyc(1);
        end
        preset_req = 0; btn_change = 0; vblank = 1;
        cyc(200);
        chk("drain_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
